// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract engine: processes CHUNK bits per clock, least
// significant digit first, with valid/ready handshakes on both sides.
module addsub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cbin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             cbout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             cb;        // running carry (add) or borrow (subtract)
  logic             mode_q;
  logic             a_sign;
  logic             b_sign;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_q;
  logic             cbout_q;
  logic             ovf_q;
  logic             zero_q;

  logic [CHUNK-1:0]       a_ck;
  logic [CHUNK-1:0]       b_ck;
  logic [CHUNK:0]         ck_ext;
  logic                   cb_nxt;
  logic [WIDTH+CHUNK-1:0] d_shift;
  logic [WIDTH-1:0]       d_nxt;
  logic                   ovf_nxt;

  assign a_ck = a_sh[CHUNK-1:0];
  assign b_ck = b_sh[CHUNK-1:0];

  // NOTE: every always_comb output gets a default before any branch so that
  // no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    ck_ext  = '0;
    cb_nxt  = 1'b0;
    ovf_nxt = 1'b0;
    if (mode_q) begin
      ck_ext = {1'b0, a_ck} + {1'b0, b_ck} + {{CHUNK{1'b0}}, cb};
    end else begin
      // A negative difference wraps, leaving the borrow in the top bit.
      ck_ext = {1'b0, a_ck} - {1'b0, b_ck} - {{CHUNK{1'b0}}, cb};
    end
    cb_nxt = ck_ext[CHUNK];

    // The new digit enters at the top; after NCHUNK steps it is aligned.
    d_shift = {ck_ext[CHUNK-1:0], d_q};
    d_nxt   = d_shift[WIDTH+CHUNK-1:CHUNK];

    if (mode_q) begin
      ovf_nxt = (a_sign == b_sign) && (d_nxt[WIDTH-1] != a_sign);
    end else begin
      ovf_nxt = (a_sign != b_sign) && (d_nxt[WIDTH-1] != a_sign);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      cb      <= 1'b0;
      mode_q  <= 1'b0;
      a_sign  <= 1'b0;
      b_sign  <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      d_q     <= '0;
      cbout_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            a_sign <= a[WIDTH-1];
            b_sign <= b[WIDTH-1];
            mode_q <= mode;
            cb     <= cbin;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          d_q  <= d_nxt;
          cb   <= cb_nxt;
          a_sh <= a_sh >> CHUNK;
          b_sh <= b_sh >> CHUNK;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST_CHUNK) begin
            cbout_q <= cb_nxt;
            ovf_q   <= ovf_nxt;
            zero_q  <= (d_nxt == '0);
            state   <= DONE;
          end
        end
        DONE: begin
          // in_valid is deliberately ignored here; accept only from IDLE.
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign d         = d_q;
  assign cbout     = cbout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq: directed and random operations against
// a plain-arithmetic reference, handshake hold, back-to-back and reset cases.
module tb_addsub_seq;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cbin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             cbout;
  logic             ovf;
  logic             zero;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             cb;
    logic             ovf;
    logic             zero;
  } res_t;

  addsub_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .cbin      (cbin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .cbout     (cbout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: exact integer arithmetic, then reduce to WIDTH bits.
  function automatic res_t model(input logic m, input logic [WIDTH-1:0] aa,
                                 input logic [WIDTH-1:0] bb, input logic ci);
    res_t   r;
    longint ua, ub, uc, full, sa, sb, sfull;
    ua = longint'(aa);
    ub = longint'(bb);
    uc = ci ? 64'd1 : 64'd0;
    sa = longint'($signed(aa));
    sb = longint'($signed(bb));
    if (m) begin
      full  = ua + ub + uc;
      r.cb  = (full >= (64'd1 << WIDTH));
      sfull = sa + sb + uc;
    end else begin
      full  = ua - ub - uc;
      r.cb  = (ua < ub + uc);
      sfull = sa - sb - uc;
    end
    r.d    = full[WIDTH-1:0];
    r.ovf  = (sfull > ((64'sd1 <<< (WIDTH-1)) - 1)) || (sfull < -(64'sd1 <<< (WIDTH-1)));
    r.zero = (r.d == '0);
    return r;
  endfunction

  // One full operation: accept, latency, result, optional hold, drain.
  task automatic run_op(input string name, input logic m, input logic [WIDTH-1:0] aa,
                        input logic [WIDTH-1:0] bb, input logic ci, input int hold);
    res_t exp_r;
    int   lat;
    bit   got;
    exp_r = model(m, aa, bb, ci);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before: in_ready=%b expected 1", name, in_ready);
    end
    mode = m; a = aa; b = bb; cbin = ci; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scramble inputs: the unit must use only what it latched.
    mode = ~m; a = $urandom; b = $urandom; cbin = ~ci;
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (out_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      lat = i;
    end
    checks++;
    if (!got || lat != NCHUNK) begin
      errors++;
      $display("FAIL %s latency: got=%0d cycles (valid=%b) expected %0d", name, lat, got, NCHUNK);
      return;
    end
    checks++;
    if (d !== exp_r.d || cbout !== exp_r.cb || ovf !== exp_r.ovf || zero !== exp_r.zero) begin
      errors++;
      $display("FAIL %s result: d=%h cbout=%b ovf=%b zero=%b expected d=%h cbout=%b ovf=%b zero=%b",
               name, d, cbout, ovf, zero, exp_r.d, exp_r.cb, exp_r.ovf, exp_r.zero);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = $urandom; b = $urandom; mode = $urandom_range(0, 1);
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || d !== exp_r.d || cbout !== exp_r.cb ||
          ovf !== exp_r.ovf || zero !== exp_r.zero) begin
        errors++;
        $display("FAIL %s hold%0d: out_valid=%b in_ready=%b d=%h cb=%b ovf=%b zero=%b expected 1 0 %h %b %b %b",
                 name, i, out_valid, in_ready, d, cbout, ovf, zero,
                 exp_r.d, exp_r.cb, exp_r.ovf, exp_r.zero);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || d !== exp_r.d || cbout !== exp_r.cb) begin
      errors++;
      $display("FAIL %s drain: out_valid=%b in_ready=%b d=%h cbout=%b expected 0 1 %h %b",
               name, out_valid, in_ready, d, cbout, exp_r.d, exp_r.cb);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0; a = '0; b = '0; cbin = 1'b0;
    #3;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || d !== '0 || cbout !== 1'b0 ||
        ovf !== 1'b0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b d=%h cbout=%b ovf=%b zero=%b expected 1 0 0 0 0 0",
               in_ready, out_valid, d, cbout, ovf, zero);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_subtract();
    run_op("sub_100_99", 1'b0, 32'd100, 32'd99, 1'b0, 0);
    run_op("sub_wrap_29_38", 1'b0, 32'd29, 32'd38, 1'b0, 0);
    run_op("sub_wrap_97201", 1'b0, 32'd97201, 32'd100095, 1'b0, 0);
    run_op("sub_borrow_in", 1'b0, 32'd120097, 32'd120095, 1'b1, 0);
    run_op("sub_ripple", 1'b0, 32'h0000_0100, 32'd1, 1'b0, 0);
    run_op("sub_ovf_min", 1'b0, 32'h8000_0000, 32'd0, 1'b1, 0);
    run_op("sub_ovf_pos", 1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
  endtask

  task automatic test_add();
    run_op("add_wrap_zero", 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b1, 0);
    run_op("add_ovf", 1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0, 0);
    run_op("add_neg_ovf", 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
    run_op("add_plain", 1'b1, 32'h0012_34FF, 32'h0000_0001, 1'b0, 0);
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] ra, rb;
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) rb = ra;
      if (i % 6 == 1) ra = {1'b0, {(WIDTH-1){1'b1}}};
      run_op("random", logic'($urandom_range(0, 1)), ra, rb, logic'($urandom_range(0, 1)), 0);
    end
  endtask

  task automatic test_hold();
    run_op("hold_sub", 1'b0, 32'd500, 32'd123, 1'b1, 10);
  endtask

  task automatic test_back_to_back();
    res_t exp_q[$];
    res_t e;
    int   n_sent, n_recv, last_cyc;
    logic m, ci;
    logic [WIDTH-1:0] ra, rb;
    n_sent = 0; n_recv = 0; last_cyc = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        if (n_sent < 4) begin
          m = $urandom_range(0, 1); ci = $urandom_range(0, 1);
          ra = $urandom; rb = $urandom;
          mode = m; a = ra; b = rb; cbin = ci; in_valid = 1'b1;
          exp_q.push_back(model(m, ra, rb, ci));
          n_sent++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b2b_spurious: out_valid=1 with no operation outstanding");
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (d !== e.d || cbout !== e.cb || ovf !== e.ovf || zero !== e.zero) begin
            errors++;
            $display("FAIL b2b_result%0d: d=%h cb=%b ovf=%b zero=%b expected %h %b %b %b",
                     n_recv, d, cbout, ovf, zero, e.d, e.cb, e.ovf, e.zero);
          end
          if (last_cyc >= 0) begin
            checks++;
            if (cyc - last_cyc != NCHUNK + 2) begin
              errors++;
              $display("FAIL b2b_period: got=%0d cycles expected %0d", cyc - last_cyc, NCHUNK + 2);
            end
          end
          last_cyc = cyc;
          n_recv++;
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n_recv != 4) begin
      errors++;
      $display("FAIL b2b_count: got=%0d results expected 4", n_recv);
    end
    for (int i = 0; i < 20 && !(in_ready === 1'b1 && out_valid === 1'b0); i++) @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    mode = 1'b1; a = 32'h1122_3344; b = 32'h0101_0101; cbin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || d !== '0 || cbout !== 1'b0 ||
        ovf !== 1'b0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: in_ready=%b out_valid=%b d=%h cbout=%b ovf=%b zero=%b expected 1 0 0 0 0 0",
               in_ready, out_valid, d, cbout, ovf, zero);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrun_discard: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
    run_op("after_reset_5_3", 1'b0, 32'd5, 32'd3, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_subtract();
    test_add();
    test_hold();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
